// File: rtl/xif_coproc_exec_queue_if.sv
// Flat XIF issue/commit/result bundle for the exec queue.
// slave = coprocessor side; master = core side (or a testbench).
interface xif_coproc_exec_queue_if #(
  parameter int unsigned X_ID_WIDTH = 4
) ();
  logic                  issue_valid_i;
  logic                  issue_ready_o;
  logic [31:0]           issue_instr_i;
  logic [X_ID_WIDTH-1:0] issue_id_i;
  logic [95:0]           issue_rs_i;
  logic [2:0]            issue_rs_valid_i;
  logic                  issue_accept_o;
  logic                  issue_writeback_o;
  logic                  commit_valid_i;
  logic [X_ID_WIDTH-1:0] commit_id_i;
  logic                  commit_kill_i;
  logic                  result_valid_o;
  logic                  result_ready_i;
  logic [X_ID_WIDTH-1:0] result_id_o;
  logic [31:0]           result_data_o;
  logic [4:0]            result_rd_o;
  logic                  result_we_o;
  logic                  busy_o;

  modport slave (
    input  issue_valid_i, issue_instr_i, issue_id_i, issue_rs_i, issue_rs_valid_i,
    input  commit_valid_i, commit_id_i, commit_kill_i, result_ready_i,
    output issue_ready_o, issue_accept_o, issue_writeback_o,
    output result_valid_o, result_id_o, result_data_o, result_rd_o, result_we_o, busy_o
  );

  modport master (
    output issue_valid_i, issue_instr_i, issue_id_i, issue_rs_i, issue_rs_valid_i,
    output commit_valid_i, commit_id_i, commit_kill_i, result_ready_i,
    input  issue_ready_o, issue_accept_o, issue_writeback_o,
    input  result_valid_o, result_id_o, result_data_o, result_rd_o, result_we_o, busy_o
  );
endinterface

// File: rtl/xif_coproc_exec_queue.sv
// XIF coprocessor execute stage: computes custom-0 results at issue, holds them in order until commit.
// Define COPROC_MINU3_EN to additionally accept funct3=010 (unsigned minimum of three).
module xif_coproc_exec_queue #(
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned X_ID_WIDTH = 4,
  parameter int unsigned X_NUM_RS   = 3,
  parameter logic [6:0]  OPCODE     = 7'h0B
) (
  input logic                    clk_i,
  input logic                    rst_ni,
  xif_coproc_exec_queue_if.slave xif
);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {FREE, WAIT_COMMIT, READY, KILLED} slot_state_e;

  slot_state_e           state_q [DEPTH];
  slot_state_e           state_d [DEPTH];
  logic [X_ID_WIDTH-1:0] id_q    [DEPTH];
  logic [4:0]            rd_q    [DEPTH];
  logic [31:0]           data_q  [DEPTH];

  logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             busy_q;

  logic [X_NUM_RS*32-1:0] rs;
  logic [31:0]            rs1, rs2, rs3, result;
  logic [6:0]             opcode;
  logic [2:0]             funct3;
  logic [4:0]             rd;
  logic                   accept, issue_ready, alloc, pop, skip, commit_new;
  slot_state_e            commit_state;
  logic [DEPTH-1:0]       at_tail, at_head, commit_hit;
  logic                   unused_instr;

  assign rs           = xif.issue_rs_i;
  assign rs1          = rs[31:0];
  assign rs2          = rs[63:32];
  assign rs3          = rs[95:64];
  assign opcode       = xif.issue_instr_i[6:0];
  assign rd           = xif.issue_instr_i[11:7];
  assign funct3       = xif.issue_instr_i[14:12];
  assign unused_instr = ^xif.issue_instr_i[31:15];

`ifdef COPROC_MINU3_EN
  logic [31:0] min12;
  assign min12 = (rs1 < rs2) ? rs1 : rs2;
`endif

  always_comb begin
    accept = 1'b0;
    result = '0;
    if (opcode == OPCODE) begin
      case (funct3)
        3'b000: begin
          accept = 1'b1;
          result = rs1 * rs2 + rs3;
        end
        3'b001: begin
          accept = 1'b1;
          result = rs1 + rs2 + rs3;
        end
`ifdef COPROC_MINU3_EN
        3'b010: begin
          accept = 1'b1;
          result = (rs3 < min12) ? rs3 : min12;
        end
`endif
        default: ;
      endcase
    end
  end

  // A pop does not free space for an issue in the same cycle: ready looks only at registered count.
  assign issue_ready  = (count_q != CNT_W'(DEPTH)) & (&xif.issue_rs_valid_i);
  assign alloc        = xif.issue_valid_i & issue_ready & accept;
  assign pop          = (state_q[head_q] == READY) & xif.result_ready_i;
  assign skip         = (state_q[head_q] == KILLED);
  assign commit_state = xif.commit_kill_i ? KILLED : READY;
  assign commit_new   = xif.commit_valid_i & (xif.commit_id_i == xif.issue_id_i);

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
    assign at_tail[gi]    = (tail_q == PTR_W'(gi));
    assign at_head[gi]    = (head_q == PTR_W'(gi));
    assign commit_hit[gi] = xif.commit_valid_i & (state_q[gi] == WAIT_COMMIT) &
                            (id_q[gi] == xif.commit_id_i);
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      state_d[i] = state_q[i];
      if (alloc && at_tail[i]) begin
        state_d[i] = commit_new ? commit_state : WAIT_COMMIT;
      end else if (commit_hit[i]) begin
        state_d[i] = commit_state;
      end else if (at_head[i] && (pop || skip)) begin
        state_d[i] = FREE;
      end
    end
    head_d = head_q;
    if (pop || skip) begin
      head_d = head_q + 1'b1;
    end
    tail_d = tail_q;
    if (alloc) begin
      tail_d = tail_q + 1'b1;
    end
    count_d = count_q + CNT_W'(alloc) - CNT_W'(pop | skip);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) begin
        state_q[i] <= FREE;
        id_q[i]    <= '0;
        rd_q[i]    <= '0;
        data_q[i]  <= '0;
      end
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (alloc) begin
        id_q[tail_q]   <= xif.issue_id_i;
        rd_q[tail_q]   <= rd;
        data_q[tail_q] <= result;
      end
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      busy_q  <= (count_d != '0);
    end
  end

  assign xif.issue_ready_o     = issue_ready;
  assign xif.issue_accept_o    = accept;
  assign xif.issue_writeback_o = accept;
  assign xif.result_valid_o    = (state_q[head_q] == READY);
  assign xif.result_we_o       = (state_q[head_q] == READY);
  assign xif.result_id_o       = id_q[head_q];
  assign xif.result_data_o     = data_q[head_q];
  assign xif.result_rd_o       = rd_q[head_q];
  assign xif.busy_o            = busy_q;
endmodule

// File: doc/xif_coproc_exec_queue.md
Name: xif_coproc_exec_queue

Overview:
- Execution and result stage of the eXtension-interface coprocessor. It sits directly downstream of the core's issue and commit channels and drives the core's result channel.
- It accepts custom-0 three-source instructions, computes the result at issue time, and parks each result in an in-order queue until the core commits it.
- Committed results are returned in issue order. Killed entries are dropped silently.
- The XIF signals appear as flat ports so the block can be unit-tested standalone. The coprocessor top binds them to the interface.

Parameters:
- DEPTH, 4: number of queue entries; must be a power of two, at least 2.
- X_ID_WIDTH, 4: width of the instruction id.
- X_NUM_RS, 3: number of source operands; the block is fixed at 3.
- OPCODE, 7'h0B: major opcode accepted (custom-0).

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- issue_valid_i  in  1  issue request valid
- issue_ready_o  out  1  issue request ready
- issue_instr_i  in  32  instruction word
- issue_id_i  in  X_ID_WIDTH  instruction id
- issue_rs_i  in  96  source operands {rs3, rs2, rs1}
- issue_rs_valid_i  in  3  operand valid flags
- issue_accept_o  out  1  instruction accepted by the coprocessor
- issue_writeback_o  out  1  instruction will write back rd
- commit_valid_i  in  1  commit strobe
- commit_id_i  in  X_ID_WIDTH  id being committed
- commit_kill_i  in  1  1 = kill, 0 = commit
- result_valid_o  out  1  result valid
- result_ready_i  in  1  result ready
- result_id_o  out  X_ID_WIDTH  id of the result
- result_data_o  out  32  result value
- result_rd_o  out  5  destination register, instr[11:7]
- result_we_o  out  1  write enable, always 1 when valid
- busy_o  out  1  one or more entries occupied

Behaviour:
- Clock and reset:
  - Single clock domain clk_i; reset rst_ni is asynchronous, active-low.
  - On reset all entries are FREE, head/tail/count are 0, and every output is 0 except issue_ready_o, which follows its combinational equation.
  - A reset mid-operation discards all entries with no result emitted.
- Issue handshake:
  - issue_ready_o = (count != DEPTH) & (&issue_rs_valid_i).
  - A handshake occurs when valid & ready. A pop in the same cycle does not raise ready, so there is no full bypass.
- Decode (combinational from issue_instr_i):
  - Accepted when instr[6:0]==OPCODE and funct3 = instr[14:12] is 000 (MADD) or 001 (ADD3); see the optional feature for 010.
  - issue_writeback_o = issue_accept_o.
  - A rejected instruction still completes the handshake, allocates nothing, and returns no result.
- Arithmetic, all results truncated to 32 bits (wrap-around):
  - MADD = rs1*rs2 + rs3, keeping the low 32 bits of the product.
  - ADD3 = rs1 + rs2 + rs3.
- Entry FSM, per slot:
  - FREE -> WAIT_COMMIT on an accepted handshake. The write goes to tail, which then increments mod DEPTH. The slot stores id, rd and data.
  - WAIT_COMMIT -> READY on commit_valid_i with a matching id and kill=0.
  - WAIT_COMMIT -> KILLED on a match with kill=1.
  - READY -> FREE when it is at head and result_valid_o & result_ready_i.
  - KILLED -> FREE when it is at head, without asserting result_valid_o, one entry per cycle.
- Commit rules:
  - Outstanding ids are unique; this is guaranteed by the core.
  - A commit whose id matches no WAIT_COMMIT entry is ignored.
  - A commit in the same cycle as the issue handshake of the same id applies to the newly allocated entry.
- Result channel:
  - result_* are driven from registered head-slot contents, with no combinational path from any input.
  - result_valid_o = (head state == READY).
  - Once valid is asserted, valid, id, data and rd stay stable until ready is asserted.
  - A head entry still in WAIT_COMMIT blocks younger READY entries, so output is in issue order.
- Count:
  - Increments on an allocation and decrements on a pop or skip; both in one cycle leaves count unchanged.
  - busy_o = (count != 0), registered.

Optional Feature:
- Macro COPROC_MINU3_EN.
- Defined: funct3=010 is accepted, with result = unsigned minimum of rs1, rs2 and rs3.
- Undefined: funct3=010 is rejected (accept=0, writeback=0, no entry allocated); no comparator logic is present.

Test Plan:
- MADD, id 2, rs1=3, rs2=5, rs3=7, rd=x10, then commit id 2 kill=0 -> result_valid_o=1, id 2, data 22, rd 10, we 1.
- MADD, rs1=0xFFFFFFFF, rs2=2, rs3=3, committed -> data 0x00000001 (wrap-around).
- ADD3 id 1, commit kill=1 -> no result_valid_o pulse; busy_o falls within 2 cycles.
- Four accepted issues, ids 0-3, no commits -> issue_ready_o=0 for a fifth. Then commit id 0 with result_ready_i=1 -> result id 0 emitted, and issue_ready_o=1 on the following cycle.
- Issue ids 4 then 5, commit 5 then 4, hold result_ready_i=0 for 10 cycles -> result_valid_o held with id 4 and stable data. After ready is asserted, id 4 is returned, then id 5.
- Issue opcode 7'h33 -> issue_accept_o=0, busy_o stays 0. With COPROC_MINU3_EN, funct3=010 on operands 9, 4, 7 -> data 4. Without the macro -> accept=0.
